karatsuba_iter: RTL and testbench
=================================

KARATSUBA_ITER -- requirements
Module: karatsuba_iter

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand width; legal values are even and >= 4.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid_i, input, 1 bit: operand pair valid.
REQ-005 SHALL have port in_ready_o, output, 1 bit: block accepts operands.
REQ-006 SHALL have port multiplicand_i, input, N bits: operand A.
REQ-007 SHALL have port multiplier_i, input, N bits: operand B.
REQ-008 SHALL have port out_valid_o, output, 1 bit: product valid.
REQ-009 SHALL have port out_ready_i, input, 1 bit: consumer accepts product.
REQ-010 SHALL have port product_o, output, 2N bits: registered product.
REQ-011 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, MUL_LO, MUL_HI, MUL_MID, OUT.
REQ-013 SHALL assert in_ready_o only in IDLE; accept = in_valid_i & in_ready_o, which registers both operands and moves to MUL_LO.
REQ-014 SHALL, in MUL_LO, compute z0 = A_lo*B_lo, register it, and move to MUL_HI.
REQ-015 SHALL, in MUL_HI, compute z2 = A_hi*B_hi, register it, and move to MUL_MID.
REQ-016 SHALL, in MUL_MID, compute m = (A_hi+A_lo)*(B_hi+B_lo) with (N/2+1)-bit sums and an (N+2)-bit result.
REQ-017 SHALL, in MUL_MID, form z1 = m - z2 - z0 and register product_o = (z2<<N) + (z1<<N/2) + z0 mod 2^(2N), then move to OUT.
REQ-018 SHALL assert out_valid_o only in OUT; on out_valid_o & out_ready_i it SHALL move to IDLE.
REQ-019 SHALL raise out_valid_o on the 3rd rising edge after the accepting edge; the minimum initiation interval is 5 cycles.
REQ-020 SHALL hold product_o stable while out_valid_o is high and out_ready_i is low, with no bound on backpressure length.
REQ-021 SHALL retain product_o after the handshake until the next MUL_MID completes.
REQ-022 SHALL ignore in_valid_i and operand changes outside IDLE.
REQ-023 SHALL use one time-shared multiplier instance for all three partial products; operands narrower than N/2+1 bits are zero-extended.

Reset
REQ-024 SHALL, while rstn_i is low, force state IDLE, in_ready_o 1, out_valid_o 0, busy_o 0, product_o 0, and all internal registers 0.
REQ-025 SHALL, on reset asserted mid-operation in any state, discard the operation without emitting a product; after release, the first edge may accept new operands.

Configuration
REQ-026 SHALL, with macro KARATSUBA_ITER_SIGNED_EN defined, add input port signed_i (1 bit), sampled at accept.
REQ-027 SHALL, when signed_i = 1, treat operands as two's complement: register magnitudes, record sign = A[N-1]^B[N-1], and negate the 2N-bit result at the MUL_MID write when sign = 1.
REQ-028 SHALL, in signed mode, handle -2^(N-1) correctly, since its magnitude fits in N unsigned bits.
REQ-029 SHALL, without the macro, omit the port and the sign logic, with unsigned operation only and identical timing.

Structure
REQ-030 SHALL place the FSM state enum typedef and width helper localparams (HALF = N/2, MIDW = N/2+1) in shared package karatsuba_pkg.
REQ-031 SHALL instantiate sub-module kmul_core: a combinational, parametrised W x W -> 2W unsigned multiplier used with W = MIDW.

Verification (N=16)
REQ-032 SHALL cover: A=0x0000, B=0x0000 -> product_o 0x00000000, out_valid_o 3 edges after accept.
REQ-033 SHALL cover: A=0xFFFF, B=0xFFFF -> 0xFFFE0001; A=0x8000, B=0x988D -> 0x4C468000.
REQ-034 SHALL cover: out_ready_i held low 5 cycles in OUT -> product_o stable, in_ready_o 0, in_valid_i pulses ignored.
REQ-035 SHALL cover: rstn_i pulsed low during MUL_HI -> out_valid_o stays 0, in_ready_o 1 immediately, next operation correct.
REQ-036 SHALL cover, with KARATSUBA_ITER_SIGNED_EN and signed_i=1: 0x8000*0x8000 -> 0x40000000; 0xFFFF*0x0001 -> 0xFFFFFFFF; with signed_i=0, 0xFFFF*0x0001 -> 0x0000FFFF.
REQ-037 SHALL cover: 200 random back-to-back pairs with random out_ready_i -> every product equals the reference A*B and no result is lost or duplicated.

Source files
------------

// File: rtl/karatsuba_pkg.sv
// Shared types and width helpers for the iterative Karatsuba multiplier.
// HALF/MIDW describe the default 16-bit build; the helper functions give
// the same widths for any operand width N chosen at instantiation.
package karatsuba_pkg;

  localparam int N_DEFAULT = 16;
  localparam int HALF      = N_DEFAULT / 2;
  localparam int MIDW      = HALF + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_LO  = 3'd1,
    MUL_HI  = 3'd2,
    MUL_MID = 3'd3,
    OUT     = 3'd4
  } state_t;

  // Half-operand width for an N-bit operand.
  function automatic int half_w(input int n);
    return n / 2;
  endfunction

  // Width of a half-operand sum (one carry bit above the half).
  function automatic int mid_w(input int n);
    return n / 2 + 1;
  endfunction

endpackage

// File: rtl/kmul_core.sv
// Combinational W x W -> 2W unsigned multiplier. The Karatsuba sequencer
// time-shares this single instance across all three partial products.
module kmul_core #(
  parameter int W = 9
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  // Both operands are zero-extended to the product width before multiplying.
  always_comb begin
    p_o = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
  end

endmodule

// File: rtl/karatsuba_iter.sv
// Iterative Karatsuba multiplier: z0, z2 and the middle product m are
// formed in three consecutive cycles on one shared multiplier, then
// combined into a registered 2N-bit product.
// Optional feature macro: KARATSUBA_ITER_SIGNED_EN adds signed_i, which
// selects two's-complement operation per transaction.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. in_ready_o is high only in IDLE, out_valid_o only in OUT;
// product_o holds its value until the next MUL_MID write.
module karatsuba_iter
  import karatsuba_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [N-1:0]   multiplicand_i,
  input  logic [N-1:0]   multiplier_i,
`ifdef KARATSUBA_ITER_SIGNED_EN
  input  logic           signed_i,
`endif
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [2*N-1:0] product_o,
  output logic           busy_o,
  output state_t         dbg_state_o
);

  localparam int HW = half_w(N);
  localparam int MW = mid_w(N);
  localparam int PW = 2 * N;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    z0_q, z0_d;
  logic [N-1:0]    z2_q, z2_d;
  logic [PW-1:0]   prod_q, prod_d;
`ifdef KARATSUBA_ITER_SIGNED_EN
  logic            sign_q, sign_d;
  logic            neg_a, neg_b;
`endif

  logic [MW-1:0]   mul_a, mul_b;
  logic [2*MW-1:0] mul_p;
  logic [PW-1:0]   m_ext, z0_ext, z2_ext, z1_ext, full_prod;

  // Select the multiplier operands for the partial product of this state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MUL_LO: begin
        mul_a = {1'b0, a_q[HW-1:0]};
        mul_b = {1'b0, b_q[HW-1:0]};
      end
      MUL_HI: begin
        mul_a = {1'b0, a_q[N-1:HW]};
        mul_b = {1'b0, b_q[N-1:HW]};
      end
      MUL_MID: begin
        mul_a = {1'b0, a_q[N-1:HW]} + {1'b0, a_q[HW-1:0]};
        mul_b = {1'b0, b_q[N-1:HW]} + {1'b0, b_q[HW-1:0]};
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  kmul_core #(
    .W(MW)
  ) u_kmul_core (
    .a_i(mul_a),
    .b_i(mul_b),
    .p_o(mul_p)
  );

  // Recombine partial products; all arithmetic is done at the full 2N width,
  // so z1 = m - z2 - z0 never wraps (it is always non-negative).
  always_comb begin
    m_ext     = {{(PW-2*MW){1'b0}}, mul_p};
    z0_ext    = {{N{1'b0}}, z0_q};
    z2_ext    = {{N{1'b0}}, z2_q};
    z1_ext    = m_ext - z2_ext - z0_ext;
    full_prod = (z2_ext << N) + (z1_ext << HW) + z0_ext;
  end

`ifdef KARATSUBA_ITER_SIGNED_EN
  // Operand signs matter only when the transaction is flagged as signed.
  always_comb begin
    neg_a = signed_i & multiplicand_i[N-1];
    neg_b = signed_i & multiplier_i[N-1];
  end
`endif

  // Next-state and datapath register updates; every register holds by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    z0_d    = z0_q;
    z2_d    = z2_q;
    prod_d  = prod_q;
`ifdef KARATSUBA_ITER_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
`ifdef KARATSUBA_ITER_SIGNED_EN
          // Magnitude of -2^(N-1) is 2^(N-1), which still fits in N bits.
          a_d    = neg_a ? -multiplicand_i : multiplicand_i;
          b_d    = neg_b ? -multiplier_i : multiplier_i;
          sign_d = neg_a ^ neg_b;
`else
          a_d    = multiplicand_i;
          b_d    = multiplier_i;
`endif
          state_d = MUL_LO;
        end
      end
      MUL_LO: begin
        z0_d    = mul_p[N-1:0];
        state_d = MUL_HI;
      end
      MUL_HI: begin
        z2_d    = mul_p[N-1:0];
        state_d = MUL_MID;
      end
      MUL_MID: begin
`ifdef KARATSUBA_ITER_SIGNED_EN
        prod_d = sign_q ? -full_prod : full_prod;
`else
        prod_d = full_prod;
`endif
        state_d = OUT;
      end
      OUT: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      z0_q    <= '0;
      z2_q    <= '0;
      prod_q  <= '0;
`ifdef KARATSUBA_ITER_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z0_q    <= z0_d;
      z2_q    <= z2_d;
      prod_q  <= prod_d;
`ifdef KARATSUBA_ITER_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == OUT);
    busy_o      = (state_q != IDLE);
    product_o   = prod_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_karatsuba_iter.sv
// Directed and random checks for karatsuba_iter (N = 16).
module tb_karatsuba_iter;

  localparam int N  = 16;
  localparam int PW = 2 * N;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  multiplicand;
  logic [N-1:0]  multiplier;
  logic          signed_v;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;
  logic [2:0]    dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [PW-1:0] exp_q[$];

  karatsuba_iter #(
    .N(N)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .multiplicand_i(multiplicand),
    .multiplier_i  (multiplier),
`ifdef KARATSUBA_ITER_SIGNED_EN
    .signed_i      (signed_v),
`endif
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .product_o     (product),
    .busy_o        (busy),
    .dbg_state_o   (dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rstn         = 1'b0;
    in_valid     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    signed_v     = 1'b0;
    out_ready    = 1'b0;
  end

  // Driver: present one operand pair, wait for the accept edge, count edges
  // until out_valid, capture the product, then complete the output handshake.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        output logic [PW-1:0] p, output int lat);
    int guard;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    signed_v     = s;
    in_valid     = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = product;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (product !== 32'h0) $display("FAIL reset_product: got %h want 00000000", product);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", dbg_state);
    else pass_cnt++;
    rstn = 1'b1;
  endtask

  task automatic test_zero();
    logic [PW-1:0] p;
    int lat;
    run_op(16'h0000, 16'h0000, 1'b0, p, lat);
    total_cnt++;
    if (p !== 32'h0) $display("FAIL zero_product: got %h want 00000000", p);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 3) $display("FAIL zero_latency: got %0d want 3", lat);
    else pass_cnt++;
  endtask

  task automatic test_corners();
    logic [N-1:0]  va[4] = '{16'hFFFF, 16'h8000, 16'h1234, 16'h00FF};
    logic [N-1:0]  vb[4] = '{16'hFFFF, 16'h988D, 16'h5678, 16'h0100};
    logic [PW-1:0] ve[4] = '{32'hFFFE0001, 32'h4C468000, 32'h06260060, 32'h0000FF00};
    logic [PW-1:0] p;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], 1'b0, p, lat);
      total_cnt++;
      if (p !== ve[i]) $display("FAIL corner_%0d: got %h want %h", i, p, ve[i]);
      else pass_cnt++;
      total_cnt++;
      if (lat !== 3) $display("FAIL corner_lat_%0d: got %0d want 3", i, lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int guard;
    bit ok_stable, ok_ready;
    logic [PW-1:0] p;
    int lat;
    @(negedge clk);
    multiplicand = 16'h0003;
    multiplier   = 16'h0005;
    signed_v     = 1'b0;
    in_valid     = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL bp_reach_out: got %b want 1", out_valid);
    else pass_cnt++;
    ok_stable = 1'b1;
    ok_ready  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid     = i[0];
      multiplicand = 16'hABCD + 16'(i);
      multiplier   = 16'h1111;
      if (product !== 32'h0000000F || out_valid !== 1'b1) ok_stable = 1'b0;
      if (in_ready !== 1'b0) ok_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++;
    if (!ok_stable || product !== 32'h0000000F)
      $display("FAIL bp_stable: got %h valid %b want 0000000f valid 1", product, out_valid);
    else pass_cnt++;
    total_cnt++;
    if (!ok_ready) $display("FAIL bp_in_ready: in_ready rose during OUT, want 0");
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || product !== 32'h0000000F)
      $display("FAIL bp_retain: got ready %b product %h want 1 0000000f", in_ready, product);
    else pass_cnt++;
    run_op(16'h0007, 16'h0009, 1'b0, p, lat);
    total_cnt++;
    if (p !== 32'h0000003F) $display("FAIL bp_next: got %h want 0000003f", p);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    logic [PW-1:0] p;
    int lat;
    @(negedge clk);
    multiplicand = 16'h1234;
    multiplier   = 16'h5678;
    signed_v     = 1'b0;
    in_valid     = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (dbg_state !== 3'd2) $display("FAIL rst_mid_in_hi: got %0d want 2", dbg_state);
    else pass_cnt++;
    rstn = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_mid_flags: got ready %b valid %b busy %b want 1 0 0", in_ready, out_valid, busy);
    else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    total_cnt++;
    if (saw_valid) $display("FAIL rst_mid_no_output: got out_valid 1 want 0");
    else pass_cnt++;
    run_op(16'h00FF, 16'h0101, 1'b0, p, lat);
    total_cnt++;
    if (p !== 32'h0000FFFF) $display("FAIL rst_mid_next: got %h want 0000ffff", p);
    else pass_cnt++;
  endtask

`ifdef KARATSUBA_ITER_SIGNED_EN
  task automatic test_signed();
    logic [N-1:0]  va[4] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h8000};
    logic [N-1:0]  vb[4] = '{16'h8000, 16'h0001, 16'h0001, 16'h0001};
    logic          vs[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [PW-1:0] ve[4] = '{32'h40000000, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF8000};
    logic [PW-1:0] p;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vs[i], p, lat);
      total_cnt++;
      if (p !== ve[i]) $display("FAIL signed_%0d: got %h want %h", i, p, ve[i]);
      else pass_cnt++;
    end
  endtask
`endif

  task automatic test_back_to_back();
    int sent = 0;
    int got  = 0;
    int errs = 0;
    int guard = 0;
    fork
      begin
        while (sent < 200 && guard < 20000) begin
          @(negedge clk);
          guard++;
          if (in_valid && !in_ready) begin
            // hold the pending pair until accepted
          end else begin
            multiplicand = 16'($urandom_range(0, 65535));
            multiplier   = 16'($urandom_range(0, 65535));
            signed_v     = 1'b0;
            in_valid     = 1'b1;
          end
          if (in_ready) begin
            exp_q.push_back({16'h0, multiplicand} * {16'h0, multiplier});
            sent++;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        int mguard = 0;
        while (got < 200 && mguard < 20000) begin
          @(negedge clk);
          mguard++;
          out_ready = ($urandom_range(0, 1) == 1);
          if (out_valid && out_ready) begin
            logic [PW-1:0] e;
            if (exp_q.size() == 0) begin
              total_cnt++;
              $display("FAIL b2b_extra: got %h with empty expected queue", product);
              errs++;
            end else begin
              e = exp_q.pop_front();
              total_cnt++;
              if (product !== e) $display("FAIL b2b_%0d: got %h want %h", got, product, e);
              else pass_cnt++;
            end
            got++;
          end
        end
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    total_cnt++;
    if (got !== 200 || sent !== 200)
      $display("FAIL b2b_count: got sent %0d received %0d want 200 200", sent, got);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL b2b_leftover: got %0d want 0", exp_q.size());
    else pass_cnt++;
    if (errs != 0) $display("FAIL b2b_extra_total: got %0d want 0", errs);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_corners();
    test_backpressure();
    test_reset_mid();
`ifdef KARATSUBA_ITER_SIGNED_EN
    test_signed();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
